mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Two-port arbiter that shares the single unified RAM between port 0 (multi-cycle CPU fetch/load/store) and port 1 (program loader / debug access).
- Grants at most one access per cycle, using round-robin priority.
- Supports an optional bounded lock so one port can own consecutive cycles for bursts.
- Drives the RAM's asynchronous-read, clocked-write interface and returns registered read data to the winning port one cycle after grant.

Parameters:
AW, 32, address width of ports and RAM.
DW, 32, data width.
MAX_LOCK, 8, maximum consecutive locked grants before a waiting port must be served (range 1..255).

Ports:
clk  in  1  clock.
reset  in  1  synchronous, active-high reset.
p0_req  in  1  port 0 access request; held until granted.
p0_we  in  1  port 0 write enable (1 = write, 0 = read).
p0_lock  in  1  port 0 requests to keep ownership after this grant.
p0_addr  in  AW  port 0 byte address.
p0_wdata  in  DW  port 0 write data.
p0_gnt  out  1  port 0 access performed this cycle (combinational).
p0_rvalid  out  1  port 0 read data valid (registered).
p0_rdata  out  DW  port 0 read data.
p1_req, p1_we, p1_lock, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
ram_addr  out  AW  RAM address.
ram_wdata  out  DW  RAM write data.
ram_we  out  1  RAM write enable; write commits at the rising clk edge.
ram_rdata  in  DW  RAM asynchronous read data for ram_addr.

Behaviour:
- Reset (synchronous, active-high):
  - p0/p1_rvalid = 0, p0/p1_rdata = 0.
  - last_gnt = 1, so port 0 wins the first tie.
  - lock_cnt = 0.
  - While reset is high, p0_gnt, p1_gnt and ram_we are forced to 0.
- Grant decision (combinational, every cycle):
  - Only one requester: that port is granted.
  - Both requesting and a lock is active (see below): the lock owner is granted.
  - Both requesting, no active lock: the port != last_gnt is granted.
  - Neither requesting: no grant.
  - At most one gnt is high per cycle.
- RAM mux:
  - Granted port drives ram_addr, ram_wdata and ram_we = pN_we.
  - No grant: ram_addr = p0_addr, ram_wdata = p0_wdata, ram_we = 0.
- Read response:
  - A granted read with we=0 at edge T gives pN_rvalid = 1 for exactly the cycle after T, with pN_rdata = ram_rdata captured at T.
  - pN_rdata holds its value until the next granted read by that port.
  - A granted write produces no rvalid.
  - Read latency is 1 cycle after grant. Write latency is 0; data is visible to a read granted in the next cycle.
- last_gnt updates to the granted port on every grant and holds when idle.
- Lock:
  - Lock is active for port N when last_gnt == N, pN_req = 1, pN_lock = 1, and lock_cnt < MAX_LOCK.
  - lock_cnt increments on each grant to a port whose lock is active and the other port is requesting.
  - lock_cnt clears when the granted port differs from last_gnt, when the granted port's lock = 0, or when there is no grant.
  - When lock_cnt reaches MAX_LOCK, the next tie goes to the waiting port, and the counter clears.
  - Worst-case wait for a requester is MAX_LOCK+1 cycles.
  - Lock has no effect while the other port is idle; the count does not advance.
- Simultaneous events:
  - A request in the same cycle as its own rvalid is legal.
  - Changing addr/we/wdata while req is high and ungranted is legal; the values sampled at the grant cycle are used.
  - Dropping req before grant is legal; no access occurs.
- Reset mid-operation: a pending rvalid is cancelled, and the arbiter restarts with port 0 priority. RAM contents are untouched.

Test Plan:
- Reset, then p0 read of 0x10 (RAM holds 0xDEADBEEF) → p0_gnt same cycle, ram_addr=0x10, p0_rvalid=1 next cycle with p0_rdata=0xDEADBEEF, p1 outputs quiet.
- Both ports request reads continuously with no lock → grants alternate p0,p1,p0,p1…; each rvalid appears on the correct port one cycle after its grant.
- p1 writes 0x12345678 to 0x40, then p0 reads 0x40 in the next cycle → ram_we=1 only in the p1 grant cycle; p0_rdata=0x12345678.
- MAX_LOCK=4, p1_lock=1 with continuous p1 requests, p0 requesting throughout → p1 granted 5 consecutive cycles (initial grant plus 4 locked), then p0 granted, then p1 again.
- p1_lock=1 with p0 idle for 20 cycles, then p0 requests → p1 keeps grants while p0 idle; p0 granted within MAX_LOCK+1 cycles of raising req.
- Assert reset in the cycle after a granted p0 read → p0_rvalid stays 0; after reset release, a tie grants p0 first.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the unified RAM.
interface mem_arbiter_if #(
    parameter int unsigned AW = 32,
    parameter int unsigned DW = 32
);
    // Port 0 (CPU fetch/load/store)
    logic          p0_req;
    logic          p0_we;
    logic          p0_lock;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_wdata;
    logic          p0_gnt;
    logic          p0_rvalid;
    logic [DW-1:0] p0_rdata;

    // Port 1 (program loader / debug)
    logic          p1_req;
    logic          p1_we;
    logic          p1_lock;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_wdata;
    logic          p1_gnt;
    logic          p1_rvalid;
    logic [DW-1:0] p1_rdata;

    // RAM side: asynchronous read, clocked write
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;

    // Arbiter view
    modport slave (
        input  p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        input  p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        input  ram_rdata,
        output p0_gnt, p0_rvalid, p0_rdata,
        output p1_gnt, p1_rvalid, p1_rdata,
        output ram_addr, ram_wdata, ram_we
    );

    // Requester/RAM view
    modport master (
        output p0_req, p0_we, p0_lock, p0_addr, p0_wdata,
        output p1_req, p1_we, p1_lock, p1_addr, p1_wdata,
        output ram_rdata,
        input  p0_gnt, p0_rvalid, p0_rdata,
        input  p1_gnt, p1_rvalid, p1_rdata,
        input  ram_addr, ram_wdata, ram_we
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin RAM arbiter with bounded burst lock and registered read return.
module mem_arbiter #(
    parameter int unsigned AW       = 32,
    parameter int unsigned DW       = 32,
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int unsigned CW = 8;

    logic          last_gnt;
    logic [CW-1:0] lock_cnt;
    logic          rvalid0_q;
    logic          rvalid1_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          below_max_c;
    logic          lock0_c;
    logic          lock1_c;
    logic          gnt0_c;
    logic          gnt1_c;
    logic          any_gnt_c;
    logic [AW-1:0] addr_c;
    logic [DW-1:0] wdata_c;
    logic          we_c;

    // A lock only counts while its owner won last and the burst budget is not spent
    assign below_max_c = lock_cnt < CW'(MAX_LOCK);
    assign lock0_c     = !last_gnt && bus.p0_req && bus.p0_lock && below_max_c;
    assign lock1_c     =  last_gnt && bus.p1_req && bus.p1_lock && below_max_c;
    assign any_gnt_c   = gnt0_c || gnt1_c;

    // Grant decision: sole requester, then lock owner, then round-robin
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
            if (bus.p0_req && !bus.p1_req) begin
                gnt0_c = 1'b1;
            end else if (bus.p1_req && !bus.p0_req) begin
                gnt1_c = 1'b1;
            end else if (bus.p0_req && bus.p1_req) begin
                if (lock0_c)       gnt0_c = 1'b1;
                else if (lock1_c)  gnt1_c = 1'b1;
                else if (last_gnt) gnt0_c = 1'b1;
                else               gnt1_c = 1'b1;
            end
        end
    end

    // RAM mux: winner drives the RAM, port 0 parks on the bus when idle
    always_comb begin
        addr_c  = bus.p0_addr;
        wdata_c = bus.p0_wdata;
        we_c    = 1'b0;
        if (gnt1_c) begin
            addr_c  = bus.p1_addr;
            wdata_c = bus.p1_wdata;
            we_c    = bus.p1_we;
        end else if (gnt0_c) begin
            we_c    = bus.p0_we;
        end
    end

    assign bus.ram_addr  = addr_c;
    assign bus.ram_wdata = wdata_c;
    assign bus.ram_we    = we_c;
    assign bus.p0_gnt    = gnt0_c;
    assign bus.p1_gnt    = gnt1_c;
    assign bus.p0_rvalid = rvalid0_q;
    assign bus.p1_rvalid = rvalid1_q;
    assign bus.p0_rdata  = rdata0_q;
    assign bus.p1_rdata  = rdata1_q;

    // Read return, round-robin pointer and lock budget
    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            last_gnt  <= 1'b1;
            lock_cnt  <= '0;
        end else begin
            rvalid0_q <= gnt0_c && !bus.p0_we;
            rvalid1_q <= gnt1_c && !bus.p1_we;
            if (gnt0_c && !bus.p0_we) rdata0_q <= bus.ram_rdata;
            if (gnt1_c && !bus.p1_we) rdata1_q <= bus.ram_rdata;

            if (any_gnt_c) last_gnt <= gnt1_c;

            // Budget only burns when the lock actually keeps the other port waiting
            if (!any_gnt_c || (gnt1_c != last_gnt) ||
                (gnt0_c && !bus.p0_lock) || (gnt1_c && !bus.p1_lock)) begin
                lock_cnt <= '0;
            end else if ((gnt0_c && lock0_c && bus.p1_req) ||
                         (gnt1_c && lock1_c && bus.p0_req)) begin
                lock_cnt <= lock_cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural async-read RAM.
module tb_mem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned ML = 4;

    logic clk;
    logic reset;
    logic preload;
    int   vectors;
    int   miscompares;

    logic [DW-1:0] mem [0:255];

    mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed RAM model
    assign bus.ram_rdata = mem[bus.ram_addr[9:2]];
    always @(posedge clk) begin
        if (preload) begin
            mem[8'h04] <= 32'hDEADBEEF;
            mem[8'h08] <= 32'hCAFEF00D;
            mem[8'h10] <= 32'h00000000;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr[9:2]] <= bus.ram_wdata;
        end
    end

    task automatic drive_idle();
        bus.p0_req = 1'b0; bus.p0_we = 1'b0; bus.p0_lock = 1'b0;
        bus.p0_addr = '0;  bus.p0_wdata = '0;
        bus.p1_req = 1'b0; bus.p1_we = 1'b0; bus.p1_lock = 1'b0;
        bus.p1_addr = '0;  bus.p1_wdata = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bus.p0_req = 1'b1; bus.p0_we = 1'b1; bus.p1_req = 1'b1;
        #1;
        vectors++;
        if (bus.p0_gnt !== 1'b0 || bus.p1_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_gnt: got p0=%b p1=%b want 0 0", bus.p0_gnt, bus.p1_gnt);
        end
        vectors++;
        if (bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ram_we: got %b want 0", bus.ram_we);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.p0_rvalid !== 1'b0 || bus.p1_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_rvalid: got p0=%b p1=%b want 0 0", bus.p0_rvalid, bus.p1_rvalid);
        end
        vectors++;
        if (bus.p0_rdata !== 32'h0 || bus.p1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rdata: got p0=%h p1=%h want 0 0", bus.p0_rdata, bus.p1_rdata);
        end
        @(negedge clk);
        reset = 1'b0; preload = 1'b0;
        drive_idle();
    endtask

    task automatic test_single_read();
        @(negedge clk);
        bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
        #1;
        vectors++;
        if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL single_gnt: got p0=%b p1=%b want 1 0", bus.p0_gnt, bus.p1_gnt);
        end
        vectors++;
        if (bus.ram_addr !== 32'h10 || bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL single_ram: got addr=%h we=%b want 10 0", bus.ram_addr, bus.ram_we);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_rdata: got v=%b d=%h want 1 deadbeef", bus.p0_rvalid, bus.p0_rdata);
        end
        vectors++;
        if (bus.p1_rvalid !== 1'b0 || bus.p1_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL single_p1_quiet: got v=%b d=%h want 0 0", bus.p1_rvalid, bus.p1_rdata);
        end
        @(negedge clk);
        drive_idle();
        @(posedge clk); #1;
        vectors++;
        if (bus.p0_rvalid !== 1'b0 || bus.p0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL single_hold: got v=%b d=%h want 0 deadbeef", bus.p0_rvalid, bus.p0_rdata);
        end
    endtask

    // last winner is p0 here, so the first tie goes to p1
    task automatic test_alternate();
        logic [3:0] pat;
        logic       e1;
        pat = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
            bus.p1_req = 1'b1; bus.p1_addr = 32'h20;
            #1;
            e1 = pat[i];
            vectors++;
            if (bus.p1_gnt !== e1 || bus.p0_gnt !== !e1) begin
                miscompares++;
                $display("FAIL alt_gnt[%0d]: got p0=%b p1=%b want %b %b", i, bus.p0_gnt, bus.p1_gnt, !e1, e1);
            end
            @(posedge clk); #1;
            vectors++;
            if (e1 ? (bus.p1_rvalid !== 1'b1 || bus.p0_rvalid !== 1'b0 || bus.p1_rdata !== 32'hCAFEF00D)
                   : (bus.p0_rvalid !== 1'b1 || bus.p1_rvalid !== 1'b0 || bus.p0_rdata !== 32'hDEADBEEF)) begin
                miscompares++;
                $display("FAIL alt_rvalid[%0d]: got v0=%b v1=%b d0=%h d1=%h want port%0d", i,
                         bus.p0_rvalid, bus.p1_rvalid, bus.p0_rdata, bus.p1_rdata, e1);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_write_read();
        @(negedge clk);
        bus.p1_req = 1'b1; bus.p1_we = 1'b1; bus.p1_addr = 32'h40; bus.p1_wdata = 32'h12345678;
        #1;
        vectors++;
        if (bus.p1_gnt !== 1'b1 || bus.ram_we !== 1'b1 || bus.ram_addr !== 32'h40 || bus.ram_wdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL wr_cycle: got g=%b we=%b a=%h d=%h want 1 1 40 12345678",
                     bus.p1_gnt, bus.ram_we, bus.ram_addr, bus.ram_wdata);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.p1_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_no_rvalid: got %b want 0", bus.p1_rvalid);
        end
        @(negedge clk);
        drive_idle();
        bus.p0_req = 1'b1; bus.p0_addr = 32'h40;
        #1;
        vectors++;
        if (bus.p0_gnt !== 1'b1 || bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_after_wr_gnt: got g=%b we=%b want 1 0", bus.p0_gnt, bus.ram_we);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'h12345678) begin
            miscompares++;
            $display("FAIL rd_after_wr_data: got v=%b d=%h want 1 12345678", bus.p0_rvalid, bus.p0_rdata);
        end
        @(negedge clk);
        drive_idle();
    endtask

    // MAX_LOCK=4: p1 gets its first grant plus 4 locked ones, then p0, then p1
    task automatic test_lock();
        logic [6:0] pat;
        logic       e1;
        pat = 7'b1011111;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
            bus.p1_req = 1'b1; bus.p1_addr = 32'h20; bus.p1_lock = 1'b1;
            #1;
            e1 = pat[i];
            vectors++;
            if (bus.p1_gnt !== e1 || bus.p0_gnt !== !e1) begin
                miscompares++;
                $display("FAIL lock_gnt[%0d]: got p0=%b p1=%b want %b %b", i, bus.p0_gnt, bus.p1_gnt, !e1, e1);
            end
            @(posedge clk);
        end
        @(negedge clk);
        drive_idle();
    endtask

    // Lock does not count while p0 is idle, so p0 waits exactly MAX_LOCK+1 grants
    task automatic test_lock_idle();
        int wait_cnt;
        bit seen;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.p1_req = 1'b1; bus.p1_lock = 1'b1; bus.p1_addr = 32'h20;
            #1;
            vectors++;
            if (bus.p1_gnt !== 1'b1 || bus.p0_gnt !== 1'b0) begin
                miscompares++;
                $display("FAIL lock_idle_gnt[%0d]: got p0=%b p1=%b want 0 1", i, bus.p0_gnt, bus.p1_gnt);
            end
            @(posedge clk);
        end
        wait_cnt = 0;
        seen = 1'b0;
        while (!seen && wait_cnt < 12) begin
            @(negedge clk);
            bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
            #1;
            wait_cnt++;
            if (bus.p0_gnt === 1'b1) seen = 1'b1;
            @(posedge clk);
        end
        vectors++;
        if (!seen || wait_cnt != int'(ML) + 1) begin
            miscompares++;
            $display("FAIL lock_idle_wait: got seen=%b cycles=%0d want 1 %0d", seen, wait_cnt, ML + 1);
        end
        @(negedge clk);
        drive_idle();
    endtask

    // Pointer sits on p0 before reset; reset must put it back so a tie goes to p0
    task automatic test_reset_mid();
        @(negedge clk);
        bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
        #1;
        vectors++;
        if (bus.p0_gnt !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pre_gnt: got %b want 1", bus.p0_gnt);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (bus.p0_gnt !== 1'b0 || bus.ram_we !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset_gnt: got g=%b we=%b want 0 0", bus.p0_gnt, bus.ram_we);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.p0_rvalid !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_rvalid: got %b want 0", bus.p0_rvalid);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.p0_req = 1'b1; bus.p0_addr = 32'h10;
        bus.p1_req = 1'b1; bus.p1_addr = 32'h20;
        #1;
        vectors++;
        if (bus.p0_gnt !== 1'b1 || bus.p1_gnt !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_tie: got p0=%b p1=%b want 1 0", bus.p0_gnt, bus.p1_gnt);
        end
        @(posedge clk); #1;
        vectors++;
        if (bus.p0_rvalid !== 1'b1 || bus.p0_rdata !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL mid_ram_kept: got v=%b d=%h want 1 deadbeef", bus.p0_rvalid, bus.p0_rdata);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        preload     = 1'b1;
        drive_idle();
        test_reset();
        test_single_read();
        test_alternate();
        test_write_read();
        test_lock();
        test_lock_idle();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
